// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and flag generator for the asynchronous FIFO.
// Accepts producer write requests, drives the memory write enable and address,
// publishes a Gray-coded write pointer, and derives full, almost-full, fill
// level and a sticky overflow flag from a synchronised copy of the read pointer.
module fifo_wptr_full #(
  parameter int unsigned ADDRSIZE     = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                wclk_i,
  input  logic                wrst_i,
  input  logic                winc_i,
  input  logic [ADDRSIZE:0]   rq_ptr_i,
  input  logic                ovf_clr_i,
  output logic                wen_o,
  output logic [ADDRSIZE-1:0] wr_addr_o,
  output logic [ADDRSIZE:0]   wptr_o,
  output logic                fifo_full_o,
  output logic                almost_full_o,
  output logic [ADDRSIZE:0]   wlevel_o,
  output logic                overflow_o
);

  localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE+1)'(AFULL_THRESH);

  logic [ADDRSIZE:0]                  wbin;
  logic [ADDRSIZE:0]                  wbin_next;
  logic [ADDRSIZE:0]                  wgray_next;
  logic [SYNC_STAGES-1:0][ADDRSIZE:0] rq_s;
  logic [ADDRSIZE:0]                  rq_sync;
  logic [ADDRSIZE:0]                  rbin_sync;
  logic [ADDRSIZE:0]                  full_ptr;
  logic [ADDRSIZE:0]                  lvl_next;
  logic                               accept;
  logic                               ovf_set;

  assign rq_sync = rq_s[SYNC_STAGES-1];

  // Accept decision; reset blocks the memory write even while winc_i is high.
  always_comb begin
    accept  = winc_i & ~fifo_full_o & ~wrst_i;
    ovf_set = winc_i & fifo_full_o;
  end

  assign wen_o     = accept;
  assign wr_addr_o = wbin[ADDRSIZE-1:0];

  // Next binary/Gray pointer for the write taking place at this edge.
  always_comb begin
    wbin_next  = wbin + {{ADDRSIZE{1'b0}}, accept};
    wgray_next = (wbin_next >> 1) ^ wbin_next;
  end

  // Gray-to-binary of the synchronised read pointer: bit j is the XOR of all Gray bits at or above j.
  always_comb begin
    rbin_sync = '0;
    for (int unsigned j = 0; j <= ADDRSIZE; j++) begin
      rbin_sync[j] = ^(rq_sync >> j);
    end
  end

  // Full comparison target and pessimistic fill level.
  always_comb begin
    full_ptr = {~rq_sync[ADDRSIZE:ADDRSIZE-1], rq_sync[ADDRSIZE-2:0]};
    lvl_next = wbin_next - rbin_sync;
  end

  // Read-pointer synchroniser: plain flop chain, no logic between stages.
  always_ff @(posedge wclk_i) begin
    if (wrst_i) begin
      rq_s <= '0;
    end else begin
      rq_s[0] <= rq_ptr_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        rq_s[i] <= rq_s[i-1];
      end
    end
  end

  // Write pointer state, published Gray pointer and registered flags.
  always_ff @(posedge wclk_i) begin
    if (wrst_i) begin
      wbin          <= '0;
      wptr_o        <= '0;
      fifo_full_o   <= 1'b0;
      almost_full_o <= 1'b0;
      wlevel_o      <= '0;
    end else begin
      wbin          <= wbin_next;
      wptr_o        <= wgray_next;
      fifo_full_o   <= (wgray_next == full_ptr);
      almost_full_o <= (lvl_next >= AFULL_LVL);
      wlevel_o      <= lvl_next;
    end
  end

  // Sticky overflow; a set event at the same edge as a clear takes priority.
  always_ff @(posedge wclk_i) begin
    if (wrst_i) begin
      overflow_o <= 1'b0;
    end else if (ovf_set) begin
      overflow_o <= 1'b1;
    end else if (ovf_clr_i) begin
      overflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full with ADDRSIZE=4, SYNC_STAGES=2, AFULL_THRESH=12.
module tb_fifo_wptr_full;

  logic       wclk_i = 1'b0;
  logic       wrst_i = 1'b1;
  logic       winc_i = 1'b0;
  logic [4:0] rq_ptr_i = '0;
  logic       ovf_clr_i = 1'b0;
  logic       wen_o;
  logic [3:0] wr_addr_o;
  logic [4:0] wptr_o;
  logic       fifo_full_o;
  logic       almost_full_o;
  logic [4:0] wlevel_o;
  logic       overflow_o;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  fifo_wptr_full #(.ADDRSIZE(4), .SYNC_STAGES(2), .AFULL_THRESH(12)) dut (
    .wclk_i(wclk_i), .wrst_i(wrst_i), .winc_i(winc_i), .rq_ptr_i(rq_ptr_i),
    .ovf_clr_i(ovf_clr_i), .wen_o(wen_o), .wr_addr_o(wr_addr_o), .wptr_o(wptr_o),
    .fifo_full_o(fifo_full_o), .almost_full_o(almost_full_o),
    .wlevel_o(wlevel_o), .overflow_o(overflow_o)
  );

  always #5 wclk_i = ~wclk_i;

  task automatic step();
    @(posedge wclk_i);
    #1;
  endtask

  function automatic logic [4:0] gray5(input int unsigned b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic test_reset();
    wrst_i = 1'b1; winc_i = 1'b1; rq_ptr_i = '0; ovf_clr_i = 1'b0;
    #1;
    n_checks++; if (wen_o !== 1'b0) begin n_fail++; $display("FAIL reset_wen_forced got=%b exp=0", wen_o); end
    step(); step();
    n_checks++; if (wptr_o !== 5'd0) begin n_fail++; $display("FAIL reset_wptr got=%h exp=0", wptr_o); end
    n_checks++; if (wr_addr_o !== 4'd0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", wr_addr_o); end
    n_checks++; if (fifo_full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", fifo_full_o); end
    n_checks++; if (almost_full_o !== 1'b0) begin n_fail++; $display("FAIL reset_afull got=%b exp=0", almost_full_o); end
    n_checks++; if (wlevel_o !== 5'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", wlevel_o); end
    n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow_o); end
    wrst_i = 1'b0; winc_i = 1'b0;
    #1;
    n_checks++; if (wen_o !== 1'b0) begin n_fail++; $display("FAIL reset_wen_idle got=%b exp=0", wen_o); end
    winc_i = 1'b1;
    #1;
    n_checks++; if (wen_o !== 1'b1) begin n_fail++; $display("FAIL reset_wen_follow got=%b exp=1", wen_o); end
    winc_i = 1'b0;
    #1;
  endtask

  task automatic test_fill();
    logic [4:0] gtab [16] = '{5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4, 5'd12,
                              5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9, 5'd8, 5'd24};
    for (int k = 0; k < 16; k++) begin
      winc_i = 1'b1;
      #1;
      n_checks++; if (wen_o !== 1'b1) begin n_fail++; $display("FAIL fill_wen[%0d] got=%b exp=1", k, wen_o); end
      n_checks++; if (wr_addr_o !== 4'(k)) begin n_fail++; $display("FAIL fill_addr[%0d] got=%0d exp=%0d", k, wr_addr_o, k); end
      step();
      n_checks++; if (wptr_o !== gtab[k]) begin n_fail++; $display("FAIL fill_wptr[%0d] got=%b exp=%b", k, wptr_o, gtab[k]); end
      n_checks++; if (wlevel_o !== 5'(k+1)) begin n_fail++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", k, wlevel_o, k+1); end
      n_checks++; if (almost_full_o !== (k+1 >= 12)) begin n_fail++; $display("FAIL fill_afull[%0d] got=%b exp=%b", k, almost_full_o, (k+1 >= 12)); end
      n_checks++; if (fifo_full_o !== (k == 15)) begin n_fail++; $display("FAIL fill_full[%0d] got=%b exp=%b", k, fifo_full_o, (k == 15)); end
    end
    winc_i = 1'b0;
    #1;
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 3; k++) begin
      winc_i = 1'b1;
      #1;
      n_checks++; if (wen_o !== 1'b0) begin n_fail++; $display("FAIL ovf_wen[%0d] got=%b exp=0", k, wen_o); end
      step();
      n_checks++; if (wptr_o !== 5'b11000) begin n_fail++; $display("FAIL ovf_wptr[%0d] got=%b exp=11000", k, wptr_o); end
      n_checks++; if (wr_addr_o !== 4'd0) begin n_fail++; $display("FAIL ovf_addr[%0d] got=%0d exp=0", k, wr_addr_o); end
      n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag[%0d] got=%b exp=1", k, overflow_o); end
      n_checks++; if (fifo_full_o !== 1'b1) begin n_fail++; $display("FAIL ovf_full[%0d] got=%b exp=1", k, fifo_full_o); end
      n_checks++; if (wlevel_o !== 5'd16) begin n_fail++; $display("FAIL ovf_level[%0d] got=%0d exp=16", k, wlevel_o); end
    end
    ovf_clr_i = 1'b1; winc_i = 1'b1;
    step();
    n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got=%b exp=1", overflow_o); end
    winc_i = 1'b0;
    step();
    n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", overflow_o); end
    ovf_clr_i = 1'b0;
    #1;
  endtask

  task automatic test_release();
    rq_ptr_i = 5'b00001;
    step();
    n_checks++; if (fifo_full_o !== 1'b1) begin n_fail++; $display("FAIL rel_full_e0 got=%b exp=1", fifo_full_o); end
    step();
    n_checks++; if (fifo_full_o !== 1'b1) begin n_fail++; $display("FAIL rel_full_e1 got=%b exp=1", fifo_full_o); end
    n_checks++; if (wlevel_o !== 5'd16) begin n_fail++; $display("FAIL rel_level_e1 got=%0d exp=16", wlevel_o); end
    step();
    n_checks++; if (fifo_full_o !== 1'b0) begin n_fail++; $display("FAIL rel_full_e2 got=%b exp=0", fifo_full_o); end
    n_checks++; if (wlevel_o !== 5'd15) begin n_fail++; $display("FAIL rel_level_e2 got=%0d exp=15", wlevel_o); end
    n_checks++; if (almost_full_o !== 1'b1) begin n_fail++; $display("FAIL rel_afull_e2 got=%b exp=1", almost_full_o); end
    winc_i = 1'b1;
    #1;
    n_checks++; if (wen_o !== 1'b1) begin n_fail++; $display("FAIL rel_wen got=%b exp=1", wen_o); end
    step();
    winc_i = 1'b0;
    n_checks++; if (wptr_o !== 5'b11001) begin n_fail++; $display("FAIL rel_wptr got=%b exp=11001", wptr_o); end
    n_checks++; if (fifo_full_o !== 1'b1) begin n_fail++; $display("FAIL rel_refull got=%b exp=1", fifo_full_o); end
    n_checks++; if (wlevel_o !== 5'd16) begin n_fail++; $display("FAIL rel_relevel got=%0d exp=16", wlevel_o); end
    #1;
  endtask

  task automatic test_wrap();
    int unsigned exp_lvl;
    wrst_i = 1'b1; winc_i = 1'b0; rq_ptr_i = '0;
    step();
    wrst_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      winc_i = 1'b1;
      rq_ptr_i = gray5((i >= 3) ? i - 3 : 0);
      #1;
      n_checks++; if (wr_addr_o !== 4'(i % 16)) begin n_fail++; $display("FAIL wrap_addr[%0d] got=%0d exp=%0d", i, wr_addr_o, i % 16); end
      step();
      // read pointer reaches the level computation two edges after sampling
      exp_lvl = (i + 1 < 6) ? i + 1 : 6;
      n_checks++; if (wptr_o !== gray5(i + 1)) begin n_fail++; $display("FAIL wrap_wptr[%0d] got=%b exp=%b", i, wptr_o, gray5(i + 1)); end
      n_checks++; if (wlevel_o !== 5'(exp_lvl)) begin n_fail++; $display("FAIL wrap_level[%0d] got=%0d exp=%0d", i, wlevel_o, exp_lvl); end
      n_checks++; if (fifo_full_o !== 1'b0) begin n_fail++; $display("FAIL wrap_full[%0d] got=%b exp=0", i, fifo_full_o); end
    end
    winc_i = 1'b0;
    rq_ptr_i = gray5(37);
    for (int k = 0; k < 4; k++) step();
    n_checks++; if (wlevel_o !== 5'd3) begin n_fail++; $display("FAIL wrap_settle got=%0d exp=3", wlevel_o); end
    n_checks++; if (almost_full_o !== 1'b0) begin n_fail++; $display("FAIL wrap_afull got=%b exp=0", almost_full_o); end
  endtask

  task automatic test_reset_mid();
    wrst_i = 1'b1; winc_i = 1'b0; rq_ptr_i = '0;
    step();
    wrst_i = 1'b0;
    winc_i = 1'b1;
    for (int k = 0; k < 9; k++) step();
    n_checks++; if (wlevel_o !== 5'd9) begin n_fail++; $display("FAIL mid_level_pre got=%0d exp=9", wlevel_o); end
    wrst_i = 1'b1;
    #1;
    n_checks++; if (wen_o !== 1'b0) begin n_fail++; $display("FAIL mid_wen_forced got=%b exp=0", wen_o); end
    step();
    n_checks++; if (wptr_o !== 5'd0) begin n_fail++; $display("FAIL mid_wptr got=%b exp=0", wptr_o); end
    n_checks++; if (wr_addr_o !== 4'd0) begin n_fail++; $display("FAIL mid_addr got=%0d exp=0", wr_addr_o); end
    n_checks++; if (wlevel_o !== 5'd0) begin n_fail++; $display("FAIL mid_level got=%0d exp=0", wlevel_o); end
    n_checks++; if (fifo_full_o !== 1'b0 || almost_full_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_flags got=%b%b%b exp=000", fifo_full_o, almost_full_o, overflow_o);
    end
    wrst_i = 1'b0;
    #1;
    n_checks++; if (wen_o !== 1'b1) begin n_fail++; $display("FAIL mid_resume_wen got=%b exp=1", wen_o); end
    step();
    winc_i = 1'b0;
    n_checks++; if (wptr_o !== 5'd1) begin n_fail++; $display("FAIL mid_resume_wptr got=%b exp=00001", wptr_o); end
    n_checks++; if (wr_addr_o !== 4'd1) begin n_fail++; $display("FAIL mid_resume_addr got=%0d exp=1", wr_addr_o); end
    n_checks++; if (wlevel_o !== 5'd1) begin n_fail++; $display("FAIL mid_resume_level got=%0d exp=1", wlevel_o); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
